avg_filter_mc: RTL

Multi-channel, parametrised successor to the single-channel 8-bit moving averager. It oversamples and averages time-multiplexed sample streams to produce higher-resolution outputs. Examples are ADC or envelope channels feeding the synth/mixer path. Each channel has its own circular sample window in a shared RAM and its own running-sum register. A per-sample mode selects moving average (one output per input) or block/decimating average (one output per 2^POWER inputs).

---
 rtl/avg_filter_mc.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/avg_filter_mc.sv
// rtl/avg_filter_mc.sv - multi-channel moving / block averaging filter
//
// Each channel keeps a circular window of 2^POWER samples in a shared RAM plus
// an exact running sum. Moving mode emits one average per sample. Block mode
// emits one average per 2^POWER samples. The pipeline has two stages, so the
// latency is 2 cycles and the throughput is one sample per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears all state and the pipeline
//   clear      synchronous flush of all channel state and in-flight results
//   mode       0 = moving average, 1 = block average (sampled with each sample)
//   in_valid   sample strobe, no backpressure
//   in_ch      channel of din; channels >= CHANNELS are dropped
//   din        unsigned sample
//   out_valid  single-cycle result strobe
//   out_ch     channel of dout (holds while out_valid = 0)
//   dout       sum >> (POWER - OUT_FRAC): DIN_W integer bits + OUT_FRAC fraction
//   primed     per-channel window-full flag (moving); one-cycle pulse (block)
module avg_filter_mc #(
  parameter int DIN_W    = 8,
  parameter int POWER    = 8,
  parameter int CHANNELS = 1,
  parameter int OUT_FRAC = 8,
  parameter int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      mode,
  input  logic                      in_valid,
  input  logic [CHW-1:0]            in_ch,
  input  logic [DIN_W-1:0]          din,
  output logic                      out_valid,
  output logic [CHW-1:0]            out_ch,
  output logic [DIN_W+OUT_FRAC-1:0] dout,
  output logic [CHANNELS-1:0]       primed
);

  localparam int SW = POWER + DIN_W;
  localparam int AW = CHW + POWER;
  localparam int OW = DIN_W + OUT_FRAC;
  localparam logic [POWER:0] FULL = {1'b1, {POWER{1'b0}}};

  // The RAM is addressed {ch, ptr}. It is sized to the full address space so
  // that the index width matches exactly. Rows of unused channels are never
  // touched.
  logic [DIN_W-1:0] ram [0:(1<<AW)-1];
  logic [DIN_W-1:0] ram_q;

  logic [SW-1:0]    sum_q  [CHANNELS];
  logic [POWER:0]   fill_q [CHANNELS];
  logic [POWER-1:0] ptr_q  [CHANNELS];
  logic [SW-1:0]    sum_n  [CHANNELS];
  logic [POWER:0]   fill_n [CHANNELS];
  logic [POWER-1:0] ptr_n  [CHANNELS];

  // Stage-1 holding registers. p_mode also acts as the mode of the most
  // recently accepted sample, which is what mode changes are detected against.
  logic             p_valid;
  logic             p_flush;
  logic             p_mode;
  logic [CHW-1:0]   p_ch;
  logic [DIN_W-1:0] p_din;

  logic                accept;
  logic [CHW-1:0]      rd_ch;
  logic [SW-1:0]       cur_sum;
  logic [POWER:0]      cur_fill;
  logic [POWER:0]      fill_inc;
  logic [POWER-1:0]    cur_ptr;
  logic [DIN_W-1:0]    old;
  logic [SW-1:0]       res_sum;
  logic                block_done;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [CHANNELS-1:0] primed_n;

  assign accept = in_valid && !clear && (32'(in_ch) < CHANNELS);
  assign rd_ch  = accept ? in_ch : '0;

  // Stage-1 arithmetic and next-state for every channel. A pending flush
  // (a mode change) zeroes all channels before the sample is applied.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sum_n[c]  = p_flush ? '0 : sum_q[c];
      fill_n[c] = p_flush ? '0 : fill_q[c];
      ptr_n[c]  = p_flush ? '0 : ptr_q[c];
    end
    cur_sum    = sum_n[p_ch];
    cur_fill   = fill_n[p_ch];
    cur_ptr    = ptr_n[p_ch];
    fill_inc   = cur_fill + 1'b1;
    old        = '0;
    res_sum    = '0;
    block_done = 1'b0;
    we         = 1'b0;
    waddr      = {p_ch, cur_ptr};
    if (p_valid) begin
      if (!p_mode) begin
        // Stale RAM is masked until the window has filled once.
        old          = (cur_fill == FULL) ? ram_q : '0;
        res_sum      = cur_sum + SW'(p_din) - SW'(old);
        we           = 1'b1;
        sum_n[p_ch]  = res_sum;
        fill_n[p_ch] = (cur_fill == FULL) ? FULL : fill_inc;
        ptr_n[p_ch]  = cur_ptr + 1'b1;
      end else begin
        res_sum = cur_sum + SW'(p_din);
        if (fill_inc == FULL) begin
          block_done   = 1'b1;
          sum_n[p_ch]  = '0;
          fill_n[p_ch] = '0;
          ptr_n[p_ch]  = '0;
        end else begin
          sum_n[p_ch]  = res_sum;
          fill_n[p_ch] = fill_inc;
          ptr_n[p_ch]  = cur_ptr + 1'b1;
        end
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      primed_n[c] = p_mode ? (block_done && (p_ch == CHW'(c)))
                           : (fill_n[c] == FULL);
    end
  end

  // The read uses the post-update pointer (ptr_n). Back-to-back samples on one
  // channel therefore read ptr+1 while stage 1 writes ptr.
  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= p_din;
    ram_q <= ram[{rd_ch, ptr_n[rd_ch]}];
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c]  <= '0;
        fill_q[c] <= '0;
        ptr_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c]  <= sum_n[c];
        fill_q[c] <= fill_n[c];
        ptr_q[c]  <= ptr_n[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_flush <= 1'b0;
      p_mode  <= 1'b0;
      p_ch    <= '0;
      p_din   <= '0;
    end else begin
      p_valid <= accept;
      p_flush <= accept && (mode != p_mode);
      if (accept) begin
        p_mode <= mode;
        p_ch   <= in_ch;
        p_din  <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      dout      <= '0;
      primed    <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      primed    <= '0;
    end else begin
      out_valid <= p_valid && (!p_mode || block_done);
      primed    <= primed_n;
      if (p_valid && (!p_mode || block_done)) begin
        out_ch <= p_ch;
        dout   <= res_sum[SW-1 -: OW];
      end
    end
  end

endmodule
